seven_seg_mux_driver: RTL and testbench

SEVEN_SEG_MUX_DRIVER -- requirements
Module: seven_seg_mux_driver

---
 rtl/seven_seg_pkg.sv | 14 +
 rtl/seven_seg_hex_decode.sv | 11 +
 rtl/seven_seg_mux_driver.sv | 83 ++++++++
 tb/tb_seven_seg_mux_driver.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: shared constants for the seven-segment scan driver
//   HEX_SEG   : 16-entry hex-to-segment table, active-low, bit order {g,f,e,d,c,b,a}
//   SEG_BLANK : all segments off
//   ANODE_OFF : level of an unselected (dark) anode line
package seven_seg_pkg;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic ANODE_OFF = 1'b1;
  localparam logic [6:0] HEX_SEG [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };
endpackage

// File: rtl/seven_seg_hex_decode.sv
// seven_seg_hex_decode: combinational hex nibble to active-low segment pattern
//   nibble : 4-bit hex value
//   seg    : 7-bit active-low segments {g,f,e,d,c,b,a}
module seven_seg_hex_decode
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);
  assign seg = HEX_SEG[nibble];
endmodule

// File: rtl/seven_seg_mux_driver.sv
// seven_seg_mux_driver: time-multiplexed seven-segment display scanner with PWM dimming
//   div_clock  : scan clock, rising edge
//   reset      : asynchronous active-high reset
//   digits     : hex nibble per digit, digit i = digits[4i+3:4i]
//   dp         : decimal-point request per digit, 1 = lit
//   digit_en   : per-digit enable, 1 = digit may light
//   brightness : on-ticks per digit slot, 0 = dark
//   anode      : active-low digit select, registered
//   seg        : active-low segments {g,f,e,d,c,b,a}, registered
//   dp_n       : active-low decimal point, registered
//   frame_tick : one-cycle pulse following each frame end, registered
// Define SEVEN_SEG_BLANK_EN to blank all anodes at dwell 0 of every slot (anti-ghosting).
module seven_seg_mux_driver
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int DWELL_W = 4
) (
  input  logic                    div_clock,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic [DWELL_W-1:0]      brightness,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic [6:0]              seg,
  output logic                    dp_n,
  output logic                    frame_tick
);
  localparam int IDX_W = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  logic [DWELL_W-1:0] dwell_cnt;
  logic [IDX_W-1:0] dig_idx;
  logic [4*NUM_DIGITS-1:0] sh_digits;
  logic [NUM_DIGITS-1:0] sh_dp, sh_en;
  logic [DWELL_W-1:0] sh_bright;
  logic last_dwell, last_idx, frame_end, blank, lit;
  logic [3:0] cur_nib;
  logic [6:0] cur_seg;
  logic [NUM_DIGITS-1:0] anode_nxt;
  // DWELL is a power of two, so the dwell counter wraps naturally at all-ones
  assign last_dwell = &dwell_cnt;
  assign last_idx = dig_idx == IDX_W'(NUM_DIGITS - 1);
  assign frame_end = last_dwell && last_idx;
`ifdef SEVEN_SEG_BLANK_EN
  assign blank = dwell_cnt == '0;
`else
  assign blank = 1'b0;
`endif
  assign cur_nib = sh_digits[{dig_idx, 2'b00} +: 4];
  assign lit = sh_en[dig_idx] && (dwell_cnt < sh_bright) && !blank;
  // flipping one bit of the all-off pattern guarantees at most one active anode
  assign anode_nxt = {NUM_DIGITS{ANODE_OFF}} ^ (NUM_DIGITS'(lit) << dig_idx);
  seven_seg_hex_decode u_dec (
    .nibble(cur_nib),
    .seg   (cur_seg)
  );
  always_ff @(posedge div_clock or posedge reset)
    if (reset) begin
      dwell_cnt  <= '0;
      dig_idx    <= '0;
      sh_digits  <= '0;
      sh_dp      <= '0;
      sh_en      <= '0;
      sh_bright  <= '0;
      anode      <= {NUM_DIGITS{ANODE_OFF}};
      seg        <= SEG_BLANK;
      dp_n       <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      dwell_cnt  <= dwell_cnt + DWELL_W'(1);
      dig_idx    <= !last_dwell ? dig_idx : last_idx ? '0 : dig_idx + IDX_W'(1);
      anode      <= anode_nxt;
      seg        <= cur_seg;
      dp_n       <= ~sh_dp[dig_idx];
      frame_tick <= frame_end;
      if (frame_end) begin
        sh_digits <= digits;
        sh_dp     <= dp;
        sh_en     <= digit_en;
        sh_bright <= brightness;
      end
    end
endmodule

// File: tb/tb_seven_seg_mux_driver.sv
// tb_seven_seg_mux_driver: randomized scoreboard bench for seven_seg_mux_driver (4 digits, 16-tick frame)
module tb_seven_seg_mux_driver;
  logic div_clock = 1'b0;
  logic reset = 1'b1;
  logic [15:0] digits;
  logic [3:0] dp, digit_en;
  logic [1:0] brightness;
  logic [3:0] anode;
  logic [6:0] seg;
  logic dp_n, frame_tick;
  typedef struct packed {
    logic [3:0] an;
    logic [6:0] sg;
    logic dpn;
    logic ft;
  } exp_t;
  exp_t q[$];
  int compared = 0;
  int mismatched = 0;
  logic [15:0] s_dig;
  logic [3:0] s_dp, s_en;
  logic [1:0] s_br;
  int t;
  seven_seg_mux_driver #(.NUM_DIGITS(4), .DWELL_W(2)) dut (
    .div_clock (div_clock),
    .reset     (reset),
    .digits    (digits),
    .dp        (dp),
    .digit_en  (digit_en),
    .brightness(brightness),
    .anode     (anode),
    .seg       (seg),
    .dp_n      (dp_n),
    .frame_tick(frame_tick)
  );
  always #5 div_clock = ~div_clock;
  function automatic logic [6:0] hexseg(input logic [3:0] n);
    logic [6:0] tbl [16];
    tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010,
            7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
            7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    return tbl[n];
  endfunction
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s at %0t: actual %0h required %0h", name, $time, act, req);
    end
  endtask
  task automatic check_reset(input string tag);
    check({tag, "_anode"}, anode, 4'hF);
    check({tag, "_seg"}, seg, 7'h7F);
    check({tag, "_dp_n"}, dp_n, 1'b1);
    check({tag, "_frame_tick"}, frame_tick, 1'b0);
  endtask
  task automatic model_reset();
    t = 0;
    s_dig = '0;
    s_dp = '0;
    s_en = '0;
    s_br = '0;
  endtask
  // expected outputs after the coming edge, from the tick position within the frame
  task automatic predict();
    exp_t e;
    int slot, dw;
    logic on;
    slot = (t % 16) / 4;
    dw = t % 4;
    on = s_en[slot] && (dw < int'(s_br));
`ifdef SEVEN_SEG_BLANK_EN
    on = on && dw != 0;
`endif
    e.an = on ? ~(4'b0001 << slot) : 4'hF;
    e.sg = hexseg(s_dig[slot*4 +: 4]);
    e.dpn = ~s_dp[slot];
    e.ft = (t % 16) == 15;
    q.push_back(e);
    if ((t % 16) == 15) begin
      s_dig = digits;
      s_dp = dp;
      s_en = digit_en;
      s_br = brightness;
    end
    t++;
  endtask
  always begin
    exp_t e;
    @(posedge div_clock);
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("anode", anode, e.an);
      check("seg", seg, e.sg);
      check("dp_n", dp_n, e.dpn);
      check("frame_tick", frame_tick, e.ft);
    end
  end
  initial begin
    bit stop;
    digits = 16'hFFFF;
    dp = 4'hF;
    digit_en = 4'hF;
    brightness = 2'd3;
    model_reset();
    repeat (3) @(posedge div_clock);
    #2;
    check_reset("reset");
    for (int f = 0; f < 30; f++) begin
      stop = 1'b0;
      for (int k = 0; k < 16 && !stop; k++) begin
        @(negedge div_clock);
        reset = 1'b0;
        case (f)
          0: begin digits = 16'h8F10; digit_en = 4'hF; brightness = 2'd3; dp = 4'b0001; end
          1: brightness = 2'd0;
          2: brightness = 2'd1;
          3: begin digit_en = 4'b0101; brightness = 2'd3; end
          4, 5: begin digits = 16'h1111; digit_en = 4'hF; end
          6: if (k == 5) digits = 16'h2222;
          21: begin digits = 16'hA5C3; dp = 4'b1010; digit_en = 4'hF; brightness = 2'd3; end
          default:
            if (k == 0) begin
              digits = 16'($urandom);
              dp = 4'($urandom);
              digit_en = 4'($urandom);
              brightness = 2'($urandom);
            end else if ($urandom_range(3) == 0) begin
              digits = 16'($urandom);
              dp = 4'($urandom);
              digit_en = 4'($urandom);
            end
        endcase
        if (f == 22 && k == 10) begin
          reset = 1'b1;
          #1;
          check_reset("async_reset");
          repeat (2) @(posedge div_clock);
          #1;
          check_reset("held_reset");
          model_reset();
          stop = 1'b1;
        end else begin
          predict();
        end
      end
    end
    @(posedge div_clock);
    #2;
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
